nibble_link_responder: RTL
==========================

Name: nibble_link_responder

Overview:
- Target-side end of the 4-bit request/response link that carries the core's merged instruction/data traffic off the 8-bit pad interface.
- Deserializes nibble request frames into one parallel 32-bit memory access and drives a req/gnt/rvalid memory port.
- Serializes the status and read data back as nibbles.
- Used in the FPGA-side memory emulator and as the bench-side model of the link.

Parameters:
- AddrWidth, 32, request address width; must be a multiple of 4. Nibble count NA = AddrWidth/4.
- TimeoutCycles, 255, cycles to wait for mem_rvalid_i before aborting; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_nib_i  in  4  request nibble
- req_valid_i  in  1  request nibble valid
- req_ready_o  out  1  request nibble accepted when valid&ready
- rsp_nib_o  out  4  response nibble
- rsp_valid_o  out  1  response nibble valid
- rsp_ready_i  in  1  response nibble consumed when valid&ready
- mem_req_o  out  1  memory request
- mem_gnt_i  in  1  memory grant
- mem_we_o  out  1  write enable
- mem_addr_o  out  AddrWidth  byte address
- mem_wdata_o  out  32  write data
- mem_be_o  out  4  byte enables
- mem_rvalid_i  in  1  response valid; exactly one per granted request, arriving at least 1 cycle after the grant
- mem_rdata_i  in  32  read data
- mem_err_i  in  1  error, qualified by mem_rvalid_i
- busy_o  out  1  high in every state except HDR

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=HDR, nibble counter=0.
  - All outputs 0, except req_ready_o=1 in HDR.
  - A frame in progress is discarded; a pending memory response after reset is ignored.
  - The memory is assumed to be reset together with this block.
- Request frame, LS nibble first:
  - Header {we, rsvd[2:0]}.
  - NA address nibbles.
  - If we=1: 8 wdata nibbles, then 1 strb nibble.
- States and transitions:
  - HDR: take the header. Go to ADDR.
  - ADDR: count NA nibbles. Then go to WDATA if we=1, else go to MREQ.
  - WDATA: take 8 nibbles.
  - STRB: take 1 nibble, then go to MREQ. For reads, mem_be_o=4'hF and mem_wdata_o=0.
  - MREQ: mem_req_o=1 with stable addr/we/wdata/be until mem_gnt_i. Grant in the same cycle req rises is legal. Then go to MWAIT.
  - MWAIT: on mem_rvalid_i, capture rdata/err. Then go to RSP.
  - RSP: emit the status nibble. For reads only, then emit 8 rdata nibbles, LS first. Return to HDR after the last handshake.
- Status nibble:
  - 4'h0 OK.
  - 4'h1 mem_err_i=1 on the response.
  - 4'h3 header rsvd!=0: the frame is still fully consumed per its we bit, MREQ/MWAIT are skipped (no memory access), and read data nibbles are sent as 0.
- Handshakes:
  - req_ready_o=1 only in HDR/ADDR/WDATA/STRB.
  - rsp_valid_o=1 only in RSP.
  - rsp_nib_o is stable while rsp_valid_o=1 && !rsp_ready_i.
  - No combinational path from rsp_ready_i or req_valid_i to any output.
- Latency:
  - Last request nibble accepted at cycle t → mem_req_o=1 at t+1.
  - mem_rvalid_i at cycle u → rsp_valid_o=1 at u+1.
  - Full back-to-back nibble throughput (1 nibble/cycle) in both directions.
- req_valid_i gaps of any length are tolerated mid-frame; the counter holds.
- The counter wraps only on state change, never mid-field.

Optional Feature:
- Macro NIBBLE_LINK_TIMEOUT_EN.
- Defined:
  - An 8-bit+ counter runs in MWAIT.
  - If TimeoutCycles cycles elapse without mem_rvalid_i, go to RSP with status 4'h2. Read data is sent as 0.
  - A late mem_rvalid_i arriving after the abort (in any state) is ignored.
- Undefined:
  - No counter; MWAIT waits indefinitely.
  - Status 4'h2 never produced; TimeoutCycles unused.

Test Plan:
- Read, no stalls: header 4'h0, addr 0x0000_1234, mem returns 0xDEAD_BEEF one cycle after the grant → mem_addr_o=0x1234, mem_we_o=0, mem_be_o=4'hF; response nibbles 0,F,E,E,B,D,A,E,D.
- Write: header 4'h8, addr 0x10, wdata 0xA5A5_0F0F, strb 4'h3, gnt held 0 for 3 cycles → mem_req_o held 4 cycles with stable fields, mem_wdata_o=0xA5A50F0F, mem_be_o=4'h3; single response nibble 0.
- Backpressure: read with rsp_ready_i toggling 1,0,0,1,... and req_valid_i gaps of 2 cycles mid-address → identical nibble sequence, no duplicates or drops, rsp_nib_o stable while stalled.
- Error paths:
  - Header 4'h1 read → no mem_req_o; response 3 followed by eight 0s.
  - mem_err_i=1 on a write → response 1.
- Reset mid-frame: rst_n=0 after 3 address nibbles, then a full read frame to 0x4 → clean HDR restart; mem_addr_o=0x4; correct response.
- With NIBBLE_LINK_TIMEOUT_EN and TimeoutCycles=8, no mem_rvalid_i → response 2 + eight 0s after 8 MWAIT cycles; a late rvalid is ignored, and the next read to 0x8 returns the correct data.

Source files
------------

// File: rtl/nibble_link_responder.sv
// rtl/nibble_link_responder.sv - nibble link target: frame deserializer, memory port, response serializer; optional MWAIT timeout via NIBBLE_LINK_TIMEOUT_EN
module nibble_link_responder #(
    parameter int AddrWidth     = 32,
    parameter int TimeoutCycles = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           req_nib_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    output logic [3:0]           rsp_nib_o,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic                 mem_req_o,
    input  logic                 mem_gnt_i,
    output logic                 mem_we_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [31:0]          mem_wdata_o,
    output logic [3:0]           mem_be_o,
    input  logic                 mem_rvalid_i,
    input  logic [31:0]          mem_rdata_i,
    input  logic                 mem_err_i,
    output logic                 busy_o
);

    localparam int NA   = AddrWidth / 4;
    localparam int CntW = $clog2((NA > 9) ? NA : 9);
    localparam logic [CntW-1:0] AddrLast  = CntW'(NA - 1);
    localparam logic [CntW-1:0] WdataLast = CntW'(7);
    localparam logic [CntW-1:0] RdataLast = CntW'(8);

    localparam logic [2:0] HDR   = 3'd0;
    localparam logic [2:0] ADDR  = 3'd1;
    localparam logic [2:0] WDATA = 3'd2;
    localparam logic [2:0] STRB  = 3'd3;
    localparam logic [2:0] MREQ  = 3'd4;
    localparam logic [2:0] MWAIT = 3'd5;
    localparam logic [2:0] RSP   = 3'd6;

    logic [2:0]           state;
    logic [CntW-1:0]      cnt;
    logic                 we_q;
    logic                 rsvd_q;
    logic [AddrWidth-1:0] addr_q;
    logic [31:0]          wdata_q;
    logic [3:0]           be_q;
    logic [35:0]          rsp_sr;
    logic                 rvalid_ok;
    logic                 timeout_hit;
    logic                 rsp_last;

    // Writes answer with the status nibble only; reads add eight data nibbles.
    assign rsp_last = we_q || (cnt == RdataLast);

`ifdef NIBBLE_LINK_TIMEOUT_EN
    localparam int TW = ($clog2(TimeoutCycles + 1) > 8) ? $clog2(TimeoutCycles + 1) : 8;
    localparam logic [TW-1:0] TLast = TW'(TimeoutCycles - 1);

    logic [TW-1:0] tcnt;
    logic [3:0]    late_cnt;

    // Every aborted access still owes one rvalid; swallow those before trusting rvalid again.
    assign rvalid_ok   = mem_rvalid_i && (late_cnt == 4'd0);
    assign timeout_hit = (state == MWAIT) && !rvalid_ok && (tcnt == TLast);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tcnt     <= '0;
            late_cnt <= 4'd0;
        end else begin
            if (state != MWAIT) begin
                tcnt <= '0;
            end else if (!rvalid_ok) begin
                tcnt <= tcnt + 1'b1;
            end
            case ({timeout_hit, mem_rvalid_i && (late_cnt != 4'd0)})
                2'b10:   late_cnt <= late_cnt + 4'd1;
                2'b01:   late_cnt <= late_cnt - 4'd1;
                default: late_cnt <= late_cnt;
            endcase
        end
    end
`else
    logic unused_timeout_cfg;

    assign rvalid_ok          = mem_rvalid_i;
    assign timeout_hit        = 1'b0;
    assign unused_timeout_cfg = (TimeoutCycles > 0);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= HDR;
            cnt     <= '0;
            we_q    <= 1'b0;
            rsvd_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= 4'h0;
            rsp_sr  <= '0;
        end else begin
            case (state)
                HDR: if (req_valid_i) begin
                    we_q    <= req_nib_i[3];
                    rsvd_q  <= |req_nib_i[2:0];
                    wdata_q <= '0;
                    be_q    <= 4'hF;
                    cnt     <= '0;
                    state   <= ADDR;
                end
                ADDR: if (req_valid_i) begin
                    addr_q[4*cnt +: 4] <= req_nib_i;
                    if (cnt == AddrLast) begin
                        cnt <= '0;
                        if (we_q) begin
                            state <= WDATA;
                        end else if (rsvd_q) begin
                            rsp_sr <= {32'h0, 4'h3};
                            state  <= RSP;
                        end else begin
                            state <= MREQ;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WDATA: if (req_valid_i) begin
                    wdata_q <= {req_nib_i, wdata_q[31:4]};
                    if (cnt == WdataLast) begin
                        cnt   <= '0;
                        state <= STRB;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STRB: if (req_valid_i) begin
                    be_q <= req_nib_i;
                    if (rsvd_q) begin
                        rsp_sr <= {32'h0, 4'h3};
                        state  <= RSP;
                    end else begin
                        state <= MREQ;
                    end
                end
                MREQ: if (mem_gnt_i) begin
                    state <= MWAIT;
                end
                MWAIT: begin
                    if (rvalid_ok) begin
                        rsp_sr <= {mem_rdata_i, 3'b000, mem_err_i};
                        cnt    <= '0;
                        state  <= RSP;
                    end else if (timeout_hit) begin
                        rsp_sr <= {32'h0, 4'h2};
                        cnt    <= '0;
                        state  <= RSP;
                    end
                end
                RSP: if (rsp_ready_i) begin
                    rsp_sr <= {4'h0, rsp_sr[35:4]};
                    if (rsp_last) begin
                        cnt   <= '0;
                        state <= HDR;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= HDR;
            endcase
        end
    end

    assign req_ready_o = (state == HDR) || (state == ADDR) || (state == WDATA) || (state == STRB);
    assign rsp_valid_o = (state == RSP);
    assign rsp_nib_o   = rsp_sr[3:0];
    assign mem_req_o   = (state == MREQ);
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_be_o    = be_q;
    assign busy_o      = (state != HDR);

endmodule
